// File: rtl/modulo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modulo_pkg
// Description : Shared constants for the modulo-family blocks: the FSM state
//               encodings and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package modulo_pkg;

    // Default operand width used by every modulo-family block
    localparam int c_DEFAULT_SIZE = 128;

    // Divider FSM state encodings
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_CALC  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/modulo_divider_step.sv
`default_nettype none
// ============================================================================
// Module      : modulo_divider_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, subtracts the
//               divisor if it fits and reports the resulting quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_divider_step #(
    parameter int SIZE = 128
) (
    input  logic [SIZE:0]   p,
    input  logic            q_msb,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE:0]   p_next,
    output logic            q_bit
);

    // The partial remainder stays below the divisor, so its top bit is
    // always zero and the shifted value {p, q_msb} equals
    // {p[SIZE-1:0], q_msb}. Working one bit wider lets the borrow out of
    // the subtraction serve directly as the sign of the trial result.
    logic [SIZE+1:0] w_shifted;
    logic [SIZE+1:0] w_diff;

    // Trial subtraction; restore the shifted value when it goes negative
    always_comb begin
        w_shifted = {p, q_msb};
        w_diff    = w_shifted - {2'b00, divisor};
        q_bit     = ~w_diff[SIZE+1];
        p_next    = q_bit ? w_diff[SIZE:0] : w_shifted[SIZE:0];
    end

endmodule
`default_nettype wire

// File: rtl/modulo_divider.sv
`default_nettype none
// ============================================================================
// Module      : modulo_divider
// Description : Multi-cycle restoring integer divider. Two independent
//               valid/ready operand channels, one valid/ready result channel
//               carrying remainder, quotient and a divide-by-zero flag.
//               Zero divisors and dividends below the divisor skip the
//               bit-serial loop.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_divider
    import modulo_pkg::*;
#(
    parameter int SIZE = c_DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_dividen_tdata,
    input  logic            input_dividen_tvalid,
    output logic            input_dividen_tready,
    input  logic [SIZE-1:0] input_divisor_tdata,
    input  logic            input_divisor_tvalid,
    output logic            input_divisor_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic [SIZE-1:0] output_quotient,
    output logic            output_error,
    output logic            output_tvalid,
    input  logic            output_tready
);

    localparam int c_CNT_W = $clog2(SIZE);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_held_dvd;
    logic               r_held_dvs;
    logic               w_held_dvd_next;
    logic               w_held_dvs_next;
    logic               r_dvd_ready;
    logic               r_dvs_ready;
    logic [SIZE-1:0]    r_dividend;
    logic [SIZE-1:0]    r_divisor;
    logic [SIZE:0]      r_p;
    logic [SIZE-1:0]    r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SIZE-1:0]    r_rem;
    logic [SIZE-1:0]    r_quot;
    logic               r_err;
    logic               r_tvalid;

    logic               w_acc_dvd;
    logic               w_acc_dvs;
    logic               w_out_hs;
    logic               w_fast;
    logic [SIZE:0]      w_step_p;
    logic               w_step_qbit;

    assign input_dividen_tready = r_dvd_ready;
    assign input_divisor_tready = r_dvs_ready;
    assign output_tdata         = r_rem;
    assign output_quotient      = r_quot;
    assign output_error         = r_err;
    assign output_tvalid        = r_tvalid;

    assign w_acc_dvd = input_dividen_tvalid && r_dvd_ready;
    assign w_acc_dvs = input_divisor_tvalid && r_dvs_ready;
    assign w_out_hs  = r_tvalid && output_tready;
    assign w_fast    = (r_divisor == '0) || (r_dividend < r_divisor);

    modulo_divider_step #(
        .SIZE (SIZE)
    ) u_step (
        .p       (r_p),
        .q_msb   (r_q[SIZE-1]),
        .divisor (r_divisor),
        .p_next  (w_step_p),
        .q_bit   (w_step_qbit)
    );

    // Next-state and held-bit logic
    always_comb begin
        w_next_state    = r_state;
        w_held_dvd_next = r_held_dvd;
        w_held_dvs_next = r_held_dvs;
        case (r_state)
            c_IDLE: begin
                if (w_acc_dvd) w_held_dvd_next = 1'b1;
                if (w_acc_dvs) w_held_dvs_next = 1'b1;
                if (w_held_dvd_next && w_held_dvs_next) w_next_state = c_CHECK;
            end
            c_CHECK: w_next_state = w_fast ? c_DONE : c_CALC;
            c_CALC: begin
                if (r_cnt == '0) w_next_state = c_DONE;
            end
            c_DONE: begin
                if (w_out_hs) begin
                    w_next_state    = c_IDLE;
                    w_held_dvd_next = 1'b0;
                    w_held_dvs_next = 1'b0;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // State, held bits and registered channel readies; a ready only rises
    // once a full cycle has been spent in IDLE with that channel empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_held_dvd  <= 1'b0;
            r_held_dvs  <= 1'b0;
            r_dvd_ready <= 1'b0;
            r_dvs_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_held_dvd  <= w_held_dvd_next;
            r_held_dvs  <= w_held_dvs_next;
            r_dvd_ready <= (r_state == c_IDLE) && (w_next_state == c_IDLE) && !w_held_dvd_next;
            r_dvs_ready <= (r_state == c_IDLE) && (w_next_state == c_IDLE) && !w_held_dvs_next;
        end
    end

    // Operand capture, division datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_err      <= 1'b0;
            r_tvalid   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_acc_dvd) r_dividend <= input_dividen_tdata;
                    if (w_acc_dvs) r_divisor  <= input_divisor_tdata;
                end
                c_CHECK: begin
                    if (r_divisor == '0) begin
                        r_quot <= '1;
                        r_rem  <= r_dividend;
                        r_err  <= 1'b1;
                    end else if (r_dividend < r_divisor) begin
                        r_quot <= '0;
                        r_rem  <= r_dividend;
                        r_err  <= 1'b0;
                    end else begin
                        r_p   <= '0;
                        r_q   <= r_dividend;
                        r_cnt <= c_CNT_LAST;
                    end
                end
                c_CALC: begin
                    r_p   <= w_step_p;
                    r_q   <= {r_q[SIZE-2:0], w_step_qbit};
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == '0) begin
                        r_rem  <= w_step_p[SIZE-1:0];
                        r_quot <= {r_q[SIZE-2:0], w_step_qbit};
                        r_err  <= 1'b0;
                    end
                end
                c_DONE: begin
                    // Valid rises on the first DONE edge and holds until taken
                    r_tvalid <= !w_out_hs;
                end
                default: r_tvalid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/modulo_divider.md
# modulo_divider

Parametrised multi-cycle integer divider for the ElGamal datapath. Accepts a dividend and a divisor on two independent valid/ready input channels. Produces the remainder, the quotient and a divide-by-zero flag on one valid/ready output channel. It supersedes the fixed-width modulo block: width is a parameter, the quotient is exposed, zero divisors are flagged, and small dividends take a fast path.

## Interface
- SIZE, 128, operand and result width in bits (≥ 2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- input_dividen_tdata  in  SIZE  dividend
- input_dividen_tvalid  in  1  dividend valid
- input_dividen_tready  out  1  dividend ready
- input_divisor_tdata  in  SIZE  divisor
- input_divisor_tvalid  in  1  divisor valid
- input_divisor_tready  out  1  divisor ready
- output_tdata  out  SIZE  remainder (dividend mod divisor)
- output_quotient  out  SIZE  quotient (dividend / divisor)
- output_error  out  1  divisor was zero
- output_tvalid  out  1  result valid
- output_tready  in  1  downstream ready

## Operation
- States: IDLE, CHECK, CALC, DONE.
- **IDLE**
  - Each input channel is accepted independently on an edge where its tvalid && tready are both high.
  - The operand is latched and a per-channel "held" bit is set.
  - A channel's tready = IDLE && !held, registered.
  - When both are held (including both accepted on the same edge), next state is CHECK.
- **CHECK** (exactly one cycle)
  - divisor == 0: quotient = all ones, remainder = dividend, error = 1, go to DONE.
  - dividend < divisor: quotient = 0, remainder = dividend, error = 0, go to DONE.
  - Otherwise: clear the partial remainder (SIZE+1 bits), load the quotient shift register with the dividend, set counter = SIZE−1, go to CALC.
- **CALC**
  - Restoring division, one bit per cycle, MSB first.
  - Per step, tentatively compute P' = {P[SIZE-1:0], Q[SIZE-1]} − {1'b0, divisor}.
    - If P' is non-negative: P = P', shift 1 into Q.
    - If P' is negative: P = {P[SIZE-1:0], Q[SIZE-1]}, shift 0 into Q.
  - After SIZE steps (counter reaches 0), load the outputs (remainder = P[SIZE-1:0]) and go to DONE.
- **DONE**
  - output_tvalid = 1; output_tdata, output_quotient and output_error are stable until output_tready is sampled high.
  - On that edge: tvalid → 0, held bits clear, next state is IDLE.
- No pipelining: one operation in flight. Input treadys stay low from capture until the output handshake completes.

## Timing
- **Reset (rst low, asynchronous):**
  - State = IDLE, held bits = 0.
  - All outputs are 0: both input treadys, output_tvalid, output_tdata, output_quotient, output_error.
  - Input treadys rise on the first edge after rst deasserts.
- **Latency** (E0 = edge on which the second operand is captured):
  - Fast paths (zero divisor or dividend < divisor): output_tvalid high after E0+2.
  - Full division: output_tvalid high after E0+SIZE+2.
- **Back-pressure:** output_tready low holds all outputs stable indefinitely. output_tvalid never drops without a handshake.
- **Return to idle:** the output handshake at edge Eh returns the block to IDLE. Input treadys are high after Eh+1. There is no bypass into the next operation.
- **Reset mid-operation:** from any state, all outputs clear immediately and the operation is discarded.
- **Equal operands:** these take the full-division path and give q = 1, r = 0.

## Structure
- Package/include `modulo_pkg`: state encodings (2-bit localparams IDLE/CHECK/CALC/DONE) and a default SIZE localparam shared by all modulo-family blocks.
- Sub-module `modulo_divider_step`: combinational restoring step, parametrised by SIZE. Inputs are P, the Q MSB and the divisor; outputs are the next P and the quotient bit.
- The top level holds the FSM, held bits, operand registers, counter ($clog2(SIZE) bits) and output registers.

## Test plan
- Dividend 100 and divisor 7 presented on the same cycle, output_tready = 1 -> output_quotient = 14, output_tdata = 2, output_error = 0, output_tvalid high after E0+SIZE+2.
- Dividend 1000003 at cycle 0, divisor 97 at cycle 5 -> dividend tready drops after cycle 0, divisor tready stays high until its capture, result q = 10309, r = 30.
- Dividend 5, divisor 69814 -> fast path with q = 0, r = 5, error = 0, output_tvalid after E0+2; divisor 0 with dividend 1000003 -> error = 1, q = all ones, r = 1000003, output_tvalid after E0+2.
- output_tready held low for 10 cycles after output_tvalid -> all outputs stable throughout; after the handshake edge, output_tvalid is 0 and both input treadys are 1 one edge later.
- SIZE = 8 boundaries:
  - 255/255 -> q = 1, r = 0.
  - 255/1 -> q = 255, r = 0.
  - 254/255 -> fast path, r = 254.
- rst pulsed low mid-CALC -> all outputs 0 asynchronously; after release, 100/7 completes correctly with no residue from the aborted operation.
